// File: rtl/pci_bus_arbiter.sv
// pci_bus_arbiter
//   Round-robin central arbiter for a shared PCI bus. Samples the active-low
//   per-master REQ lines, drives exactly one active-low GNT at a time, follows
//   bus ownership through FRAME/IRDY, revokes grants that are never used and
//   optionally parks the bus on a default master while nobody is requesting.
//
// Ports
//   clk          bus clock, rising edge
//   RST          synchronous reset, active-low
//   REQ          per-master request, active-low (bit i = master i)
//   FRAME, IRDY  bus handshake, active-low, monitored only
//   GNT          per-master grant, active-low, registered, at most one bit low
//   owner        index of the last granted / current master
//   bus_busy     high while a transaction is in progress
//   gnt_timeout  one-clock pulse when an unused grant is revoked
module pci_bus_arbiter #(
  parameter int N_MST       = 4,
  parameter int OWN_W       = 2,
  parameter int GNT_TIMEOUT = 16,
  parameter int PARK_EN     = 1,
  parameter int PARK_ID     = 0
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [N_MST-1:0] REQ,
  input  logic             FRAME,
  input  logic             IRDY,
  output logic [N_MST-1:0] GNT,
  output logic [OWN_W-1:0] owner,
  output logic             bus_busy,
  output logic             gnt_timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, BUSY, TURN} state_t;

  localparam logic [OWN_W-1:0] PARK_IDX = OWN_W'(PARK_ID);
  localparam logic [7:0]       TMO_LAST = 8'(GNT_TIMEOUT - 1);
  localparam logic [N_MST-1:0] GNT_NONE = '1;

  state_t           state, state_nx;
  logic [N_MST-1:0] gnt_q, gnt_nx;
  logic [OWN_W-1:0] owner_q, owner_nx;
  logic [OWN_W-1:0] rr_ptr, rr_nx;
  logic             busy_q, busy_nx;
  logic             tmo_q, tmo_nx;
  logic [7:0]       cnt, cnt_nx;

  logic             req_any;
  logic [OWN_W-1:0] winner;
  logic [OWN_W-1:0] idx;
  logic             owner_req;
  logic             parked;

  // Active-low one-cold grant vector for master m.
  function automatic logic [N_MST-1:0] gnt_for(input logic [OWN_W-1:0] m);
    gnt_for = ~(N_MST'(1) << m);
  endfunction

  // Round-robin search starting just after the pointer, first low REQ wins.
  always_comb begin
    req_any = 1'b0;
    winner  = rr_ptr;
    idx     = '0;
    for (int i = 1; i <= N_MST; i++) begin
      idx = OWN_W'((int'(rr_ptr) + i) % N_MST);
      if (!req_any && ((REQ & ~gnt_for(idx)) == '0)) begin
        req_any = 1'b1;
        winner  = idx;
      end
    end
  end

  assign owner_req = |(~REQ & ~gnt_for(owner_q));
  assign parked    = (PARK_EN != 0) && (gnt_q == gnt_for(PARK_IDX));

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt_q;
    owner_nx = owner_q;
    rr_nx    = rr_ptr;
    busy_nx  = busy_q;
    tmo_nx   = 1'b0;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (parked && !FRAME) begin
          // The parked master started a transaction without arbitrating.
          state_nx = BUSY;
          gnt_nx   = GNT_NONE;
          busy_nx  = 1'b1;
          owner_nx = PARK_IDX;
          rr_nx    = PARK_IDX;
        end else if (req_any) begin
          // Bus is idle, so a parked grant may move straight to the winner.
          state_nx = GRANT;
          gnt_nx   = gnt_for(winner);
          owner_nx = winner;
          cnt_nx   = '0;
        end else if (PARK_EN != 0) begin
          gnt_nx   = gnt_for(PARK_IDX);
          owner_nx = PARK_IDX;
        end else begin
          gnt_nx   = GNT_NONE;
        end
      end
      GRANT: begin
        if (!FRAME) begin
          state_nx = BUSY;
          gnt_nx   = GNT_NONE;
          busy_nx  = 1'b1;
          rr_nx    = owner_q;
        end else if (!owner_req) begin
          state_nx = IDLE;
          gnt_nx   = GNT_NONE;
        end else if (cnt == TMO_LAST) begin
          // Skip the idle owner so it cannot starve the others.
          state_nx = IDLE;
          gnt_nx   = GNT_NONE;
          tmo_nx   = 1'b1;
          rr_nx    = owner_q;
        end else if (cnt != 8'hFF) begin
          cnt_nx   = cnt + 8'd1;
        end
      end
      BUSY: begin
        gnt_nx = GNT_NONE;
        if (FRAME && IRDY) begin
          state_nx = TURN;
          busy_nx  = 1'b0;
        end
      end
      TURN: begin
        gnt_nx   = GNT_NONE;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      state   <= IDLE;
      gnt_q   <= GNT_NONE;
      owner_q <= PARK_IDX;
      rr_ptr  <= OWN_W'(N_MST - 1);
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_nx;
      gnt_q   <= gnt_nx;
      owner_q <= owner_nx;
      rr_ptr  <= rr_nx;
      busy_q  <= busy_nx;
      tmo_q   <= tmo_nx;
      cnt     <= cnt_nx;
    end
  end

  assign GNT         = gnt_q;
  assign owner       = owner_q;
  assign bus_busy    = busy_q;
  assign gnt_timeout = tmo_q;

endmodule
